// File: rtl/dff_pkg.sv
// Shared helpers for the dff_pipe delay line: counter width and default reset fill.
package dff_pkg;

  localparam bit DEF_RST_BIT = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline slot: data register plus valid bit, async reset, clr > en > hold.
module dff_stage
  import dff_pkg::*;
#(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{DEF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Stallable fixed-latency delay line of DEPTH stages with per-stage valid and occupancy count.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEF_RST_BIT}},
  localparam int unsigned     CNT_W   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CNT_W-1:0] fill
);

  logic [WIDTH-1:0] data [DEPTH];
  logic             vld  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .d_valid (d_valid),
        .q       (data[i]),
        .q_valid (vld[i])
      );
    end else begin : g_body
      dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .d       (data[i-1]),
        .d_valid (vld[i-1]),
        .q       (data[i]),
        .q_valid (vld[i])
      );
    end
  end

  assign q       = data[DEPTH-1];
  assign q_valid = vld[DEPTH-1];

  // Incremental count mirrors the shift: one word enters, the last stage's word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (en) begin
      fill <= fill + CNT_W'(d_valid) - CNT_W'(q_valid);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed plus random checks of dff_pipe against a history-queue reference model.
module tb_dff_pipe;

  localparam int unsigned D8  = 4;
  localparam logic [7:0]  RV8 = 8'hA5;
  localparam logic        RV1 = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       en8 = 1'b0, clr8 = 1'b0, dv8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [7:0] q8;
  logic       qv8;
  logic [2:0] fill8;

  logic       en1 = 1'b0, clr1 = 1'b0, dv1 = 1'b0;
  logic       d1 = 1'b0;
  logic       q1;
  logic       qv1;
  logic [0:0] fill1;

  // Model: the last DEPTH enabled inputs since reset/clear, oldest first.
  logic [8:0] h8[$];
  logic [1:0] h1[$];

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .clr(clr8), .d(d8), .d_valid(dv8),
    .q(q8), .q_valid(qv8), .fill(fill8)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clr(clr1), .d(d1), .d_valid(dv1),
    .q(q1), .q_valid(qv1), .fill(fill1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag);
    logic [7:0] eq;
    logic       ev;
    int         cnt;
    eq  = (h8.size() == D8) ? h8[0][7:0] : RV8;
    ev  = (h8.size() == D8) ? h8[0][8]   : 1'b0;
    cnt = 0;
    foreach (h8[i]) if (h8[i][8]) cnt++;
    chk({tag, ".q"}, 32'(q8), 32'(eq));
    chk({tag, ".q_valid"}, 32'(qv8), 32'(ev));
    chk({tag, ".fill"}, 32'(fill8), 32'(cnt));
  endtask

  task automatic check1(input string tag);
    logic eq, ev;
    eq = (h1.size() == 1) ? h1[0][0] : RV1;
    ev = (h1.size() == 1) ? h1[0][1] : 1'b0;
    chk({tag, ".q1"}, 32'(q1), 32'(eq));
    chk({tag, ".q_valid1"}, 32'(qv1), 32'(ev));
    chk({tag, ".fill1"}, 32'(fill1), 32'(ev));
  endtask

  task automatic step8(input string tag, input logic e, input logic c, input logic [7:0] dd, input logic dv);
    en8 = e; clr8 = c; d8 = dd; dv8 = dv;
    @(posedge clk);
    #1;
    if (c) h8.delete();
    else if (e) begin
      h8.push_back({dv, dd});
      if (h8.size() > D8) void'(h8.pop_front());
    end
    check8(tag);
    @(negedge clk);
    en8 = 1'b0; clr8 = 1'b0;
  endtask

  task automatic step1(input string tag, input logic e, input logic c, input logic dd, input logic dv);
    en1 = e; clr1 = c; d1 = dd; dv1 = dv;
    @(posedge clk);
    #1;
    if (c) h1.delete();
    else if (e) begin
      h1.push_back({dv, dd});
      if (h1.size() > 1) void'(h1.pop_front());
    end
    check1(tag);
    @(negedge clk);
    en1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic mid_reset(input string tag);
    #5 rst_n = 1'b0;
    #1;
    h8.delete();
    h1.delete();
    check8(tag);
    check1(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset acts mid-cycle before any clock edge
    #10 rst_n = 1'b0;
    #1;
    check8("reset");
    check1("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 2: streaming fill ramp
    for (int i = 1; i <= 5; i++) step8("stream", 1'b1, 1'b0, 8'(i), 1'b1);

    // 3: stall while full, then resume
    for (int i = 0; i < 3; i++) step8("stall", 1'b0, 1'b0, 8'($urandom), 1'($urandom));
    for (int i = 6; i <= 9; i++) step8("resume", 1'b1, 1'b0, 8'(i), 1'b1);

    // 4: bubbles with X data on invalid slots
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step8("bubble", 1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
      else            step8("bubble", 1'b1, 1'b0, 'x, 1'b0);
      chk("bubble.fill_known", 32'($isunknown(fill8)), 32'd0);
      chk("bubble.qv_known", 32'($isunknown(qv8)), 32'd0);
    end

    // 5: clear beats enable
    for (int i = 0; i < 4; i++) step8("refill", 1'b1, 1'b0, 8'(8'h70 + i), 1'b1);
    step8("clr_pri", 1'b1, 1'b1, 8'hEE, 1'b1);

    // random traffic on the 8x4 pipe, with one reset mid-stream
    for (int i = 0; i < 60; i++) begin
      step8("rand8", 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
            8'($urandom), 1'($urandom));
      if (i == 30) mid_reset("rst_mid8");
    end

    // 6: DEPTH=1 corner
    for (int i = 0; i < 6; i++) step1("toggle", 1'b1, 1'b0, 1'(i), 1'b1);
    mid_reset("rst_mid1");
    step1("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    step1("post_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    step1("post_rst", 1'b0, 1'b0, 1'b1, 1'b1);
    step1("clr1", 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      step1("rand1", 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
            1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
